// File: rtl/pipelined_carry_adder_nbit_with_enable.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_carry_adder_nbit_with_enable
// Description : WIDTH-bit add/subtract split into STAGES equal chunks, one
//               chunk per pipeline stage, carry registered between stages.
//               One operation per cycle, tracked by a valid bit; a global
//               enable freezes every register.
// Ports       : clk, rst (sync, active high), enable, valid_in,
//               a, b [WIDTH], cin, sub  -> sum [WIDTH], cout, ovf, valid_out
// Revision    : 1.0 - initial release
// ============================================================================
module pipelined_carry_adder_nbit_with_enable #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             enable,
    input  wire logic             valid_in,
    input  wire logic [WIDTH-1:0] a,
    input  wire logic [WIDTH-1:0] b,
    input  wire logic             cin,
    input  wire logic             sub,
    output logic      [WIDTH-1:0] sum,
    output logic                  cout,
    output logic                  ovf,
    output logic                  valid_out
);

    localparam int c_cw = WIDTH / STAGES;

    if ((STAGES < 1) || (STAGES > WIDTH) || ((WIDTH % STAGES) != 0)) begin : g_param_check
        $error("pipelined_carry_adder_nbit_with_enable: WIDTH must be a multiple of STAGES, 1 <= STAGES <= WIDTH");
    end

    // Subtraction is a + ~b + 1; cin only matters for addition.
    logic [WIDTH-1:0]  w_beff;
    logic              w_cin;
    assign w_beff = sub ? ~b : b;
    assign w_cin  = sub ? 1'b1 : cin;

    logic [STAGES-1:0] r_vld;        // valid bit travelling with each stage
    logic [STAGES-1:0] w_stg_c;      // registered carry out of each stage
    logic [WIDTH-1:0]  w_res;        // de-skewed result, aligned with r_vld[STAGES-1]
    logic              w_fin_ovf;    // overflow flag registered by the last stage

    logic [WIDTH-1:0]  r_sum;
    logic              r_cout;
    logic              r_ovf;
    logic              r_vout;

    // ------------------------------------------------------------------
    // Valid pipeline
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld <= '0;
        end else if (enable) begin
            r_vld[0] <= valid_in;
            for (int i = 1; i < STAGES; i++) begin
                r_vld[i] <= r_vld[i-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-chunk datapath
    // ------------------------------------------------------------------
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [c_cw-1:0] w_a;
        logic [c_cw-1:0] w_b;
        logic            w_c;
        logic [c_cw:0]   w_add;
        logic [c_cw-1:0] r_csum;
        logic            r_c;

        if (k == 0) begin : g_first
            assign w_a = a[c_cw-1:0];
            assign w_b = w_beff[c_cw-1:0];
            assign w_c = w_cin;
        end else begin : g_skew
            // Chunk k is delayed k cycles so it meets the carry of stage k-1.
            logic [c_cw-1:0] r_a_skw [k];
            logic [c_cw-1:0] r_b_skw [k];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < k; i++) begin
                        r_a_skw[i] <= '0;
                        r_b_skw[i] <= '0;
                    end
                end else if (enable) begin
                    r_a_skw[0] <= a[k*c_cw +: c_cw];
                    r_b_skw[0] <= w_beff[k*c_cw +: c_cw];
                    for (int i = 1; i < k; i++) begin
                        r_a_skw[i] <= r_a_skw[i-1];
                        r_b_skw[i] <= r_b_skw[i-1];
                    end
                end
            end

            assign w_a = r_a_skw[k-1];
            assign w_b = r_b_skw[k-1];
            assign w_c = w_stg_c[k-1];
        end

        assign w_add = {1'b0, w_a} + {1'b0, w_b} + {{c_cw{1'b0}}, w_c};

        always_ff @(posedge clk) begin
            if (rst) begin
                r_csum <= '0;
                r_c    <= 1'b0;
            end else if (enable) begin
                r_csum <= w_add[c_cw-1:0];
                r_c    <= w_add[c_cw];
            end
        end

        assign w_stg_c[k] = r_c;

        // Lower chunks finish early; hold them back so every chunk of one
        // operation lines up with the last stage.
        if (k == STAGES - 1) begin : g_no_dsk
            assign w_res[k*c_cw +: c_cw] = r_csum;
        end else begin : g_dsk
            localparam int c_dly = STAGES - 1 - k;
            logic [c_cw-1:0] r_dsk [c_dly];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < c_dly; i++) begin
                        r_dsk[i] <= '0;
                    end
                end else if (enable) begin
                    r_dsk[0] <= r_csum;
                    for (int i = 1; i < c_dly; i++) begin
                        r_dsk[i] <= r_dsk[i-1];
                    end
                end
            end

            assign w_res[k*c_cw +: c_cw] = r_dsk[c_dly-1];
        end

        if (k == STAGES - 1) begin : g_last
            // Carry into the MSB is a^b^sum at that bit; overflow is that
            // carry XOR the carry out of the MSB.
            logic w_ovf;
            logic r_fovf;
            assign w_ovf = w_a[c_cw-1] ^ w_b[c_cw-1] ^ w_add[c_cw-1] ^ w_add[c_cw];

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_fovf <= 1'b0;
                end else if (enable) begin
                    r_fovf <= w_ovf;
                end
            end

            assign w_fin_ovf = r_fovf;
        end
    end

    // ------------------------------------------------------------------
    // Output registers: only load on a valid result, hold otherwise
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum  <= '0;
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
            r_vout <= 1'b0;
        end else if (enable) begin
            r_vout <= r_vld[STAGES-1];
            if (r_vld[STAGES-1]) begin
                r_sum  <= w_res;
                r_cout <= w_stg_c[STAGES-1];
                r_ovf  <= w_fin_ovf;
            end
        end
    end

    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;
    // Gated by enable so a stalled result is not reported on every frozen cycle.
    assign valid_out = r_vout & enable;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_carry_adder_nbit_with_enable.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipelined_carry_adder_nbit_with_enable
// Description : Directed self-checking bench for the pipelined adder
//               (WIDTH=16, STAGES=4), hand-computed expected values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipelined_carry_adder_nbit_with_enable;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        valid_in;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic        valid_out;

    int checks   = 0;
    int failures = 0;

    pipelined_carry_adder_nbit_with_enable #(
        .WIDTH  (16),
        .STAGES (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .valid_in  (valid_in),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .valid_out (valid_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input logic v, input logic [15:0] ai, input logic [15:0] bi,
                          input logic ci, input logic si);
        valid_in = v;
        a        = ai;
        b        = bi;
        cin      = ci;
        sub      = si;
    endtask

    // Issue one op, confirm nothing emerges early, then check the result
    // exactly 4 edges after capture and that valid drops the cycle after.
    task automatic run_op(input string tag, input logic [15:0] ai, input logic [15:0] bi,
                          input logic ci, input logic si, input logic [15:0] es,
                          input logic ec, input logic eo);
        set_op(1'b1, ai, bi, ci, si);
        tick();
        set_op(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        for (int i = 1; i < 4; i++) begin
            tick();
            chk({tag, "_early_valid"}, {31'd0, valid_out}, 32'd0);
        end
        tick();
        chk({tag, "_valid"}, {31'd0, valid_out}, 32'd1);
        chk({tag, "_sum"},   {16'd0, sum},       {16'd0, es});
        chk({tag, "_cout"},  {31'd0, cout},      {31'd0, ec});
        chk({tag, "_ovf"},   {31'd0, ovf},       {31'd0, eo});
        tick();
        chk({tag, "_valid_once"}, {31'd0, valid_out}, 32'd0);
        chk({tag, "_sum_hold"},   {16'd0, sum},       {16'd0, es});
    endtask

    initial begin
        rst    = 1'b1;
        enable = 1'b1;
        set_op(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        chk("reset_valid", {31'd0, valid_out}, 32'd0);
        chk("reset_sum",   {16'd0, sum},       32'd0);
        chk("reset_cout",  {31'd0, cout},      32'd0);
        chk("reset_ovf",   {31'd0, ovf},       32'd0);

        // Full carry ripple across every stage
        run_op("ripple",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        // Subtract, borrow and no borrow; cin must be ignored
        run_op("sub_brw", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        run_op("sub_ok",  16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0);
        // Signed overflow, add and subtract
        run_op("ovf_add", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_op("ovf_sub", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        // cin used in add mode
        run_op("add_cin", 16'h00F0, 16'h000F, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0);

        // Streaming, back-to-back then a bubble
        set_op(1'b1, 16'h0001, 16'h0001, 1'b0, 1'b0); tick();
        set_op(1'b1, 16'h00FF, 16'h0001, 1'b0, 1'b0); tick();
        set_op(1'b1, 16'h0FFF, 16'h0001, 1'b0, 1'b0); tick();
        set_op(1'b1, 16'h1234, 16'h4321, 1'b0, 1'b0); tick();
        set_op(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);       tick();
        chk("stream0_valid", {31'd0, valid_out}, 32'd1);
        chk("stream0_sum",   {16'd0, sum},       32'h0002);
        tick();
        chk("stream1_valid", {31'd0, valid_out}, 32'd1);
        chk("stream1_sum",   {16'd0, sum},       32'h0100);
        tick();
        chk("stream2_valid", {31'd0, valid_out}, 32'd1);
        chk("stream2_sum",   {16'd0, sum},       32'h1000);
        tick();
        chk("stream3_valid", {31'd0, valid_out}, 32'd1);
        chk("stream3_sum",   {16'd0, sum},       32'h5555);
        tick();
        chk("stream_bubble_valid", {31'd0, valid_out}, 32'd0);
        chk("stream_bubble_sum",   {16'd0, sum},       32'h5555);

        // Stall: two ops, enable low for 3 edges starting at the 3rd edge
        set_op(1'b1, 16'h0010, 16'h0020, 1'b0, 1'b0); tick();
        set_op(1'b1, 16'h0100, 16'h0200, 1'b0, 1'b0); tick();
        // Garbage presented during the stall must be ignored
        set_op(1'b1, 16'hDEAD, 16'hBEEF, 1'b1, 1'b0);
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_valid", {31'd0, valid_out}, 32'd0);
            chk("stall_sum",   {16'd0, sum},       32'h5555);
            chk("stall_cout",  {31'd0, cout},      32'd0);
        end
        enable = 1'b1;
        set_op(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        tick();
        chk("stall_late0", {31'd0, valid_out}, 32'd0);
        tick();
        chk("stall_late1", {31'd0, valid_out}, 32'd0);
        tick();
        chk("stall_res0_valid", {31'd0, valid_out}, 32'd1);
        chk("stall_res0_sum",   {16'd0, sum},       32'h0030);
        tick();
        chk("stall_res1_valid", {31'd0, valid_out}, 32'd1);
        chk("stall_res1_sum",   {16'd0, sum},       32'h0300);
        tick();
        chk("stall_nodup", {31'd0, valid_out}, 32'd0);
        chk("stall_hold",  {16'd0, sum},       32'h0300);

        // Reset mid-flight: three ops, reset at the 3rd edge
        set_op(1'b1, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0); tick();
        set_op(1'b1, 16'h7FFF, 16'h7FFF, 1'b0, 1'b0); tick();
        set_op(1'b1, 16'h1111, 16'h2222, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_op(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        chk("midrst_valid", {31'd0, valid_out}, 32'd0);
        chk("midrst_sum",   {16'd0, sum},       32'd0);
        chk("midrst_cout",  {31'd0, cout},      32'd0);
        chk("midrst_ovf",   {31'd0, ovf},       32'd0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("midrst_flushed", {31'd0, valid_out}, 32'd0);
            chk("midrst_sum_zero", {16'd0, sum}, 32'd0);
        end
        run_op("post_rst", 16'h0003, 16'h0004, 1'b0, 1'b0, 16'h0007, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipelined_carry_adder_nbit_with_enable.md
Name: pipelined_carry_adder_nbit_with_enable

Overview:
Parametrised, pipelined successor to the 4-bit enabled parallel carry adder.
- Splits a WIDTH-bit add/subtract into STAGES equal chunks, one chunk per pipeline stage, with the carry registered between stages.
- Accepts one operation per cycle and tracks it with a valid bit.
- Global enable freezes the whole pipeline.
- Used in the arithmetic datapath wherever a wide add does not close timing in one cycle.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of STAGES.
- STAGES, 4, pipeline depth; chunk width CW = WIDTH/STAGES. Legal range 1..WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- enable  input  1  1 = pipeline advances; 0 = every register holds
- valid_in  input  1  operands/cin/sub are a valid operation this cycle
- a  input  WIDTH  operand A, unsigned or two's complement
- b  input  WIDTH  operand B
- cin  input  1  carry in; used only when sub=0
- sub  input  1  0 = a+b+cin; 1 = a-b, i.e. a+~b+1, cin ignored
- sum  output  WIDTH  registered result
- cout  output  1  carry out of MSB; in subtract mode 1 = no borrow (a>=b unsigned)
- ovf  output  1  signed overflow
- valid_out  output  1  sum/cout/ovf hold a new result this cycle

Behaviour:
Reset:
- rst=1 at a rising edge clears all stage valid bits, carry registers, skew registers and outputs.
- After reset: sum=0, cout=0, ovf=0, valid_out=0.
- rst has priority over enable.
- Operations in flight when rst asserts are discarded and never appear.

Input handling:
- The effective B operand is sub ? ~b : b.
- The effective carry in is sub ? 1 : cin.
- At capture, operand chunks k=1..STAGES-1 enter skew shift registers of depth k.
- Chunk k is added in stage k, which lines each chunk up with the carry from stage k-1.

Stage k (k=0..STAGES-1):
- Computes chunk_sum = A_k + B_k + carry_{k-1}, where carry_{-1} = effective cin.
- Registers the CW-bit result and carry_k.
- Lower result chunks are de-skewed by delay registers so that all chunks of one operation reach the output in the same cycle.

Latency and throughput:
- With enable=1 continuously, an operation with valid_in=1 at edge N produces valid_out=1 and its result at edge N+STAGES.
- Throughput is one operation per cycle.
- Results emerge in issue order.

Bubbles:
- A cycle with valid_in=0 propagates as a bubble.
- Data registers may load don't-care values.
- sum/cout/ovf update only when the final-stage valid is 1; otherwise they hold the last valid result.

Enable:
- With enable=0, every register (data, carry, valid, outputs) holds.
- valid_out = final_valid & enable, so a result is never reported twice while stalled.
- Inputs presented while enable=0 are ignored.
- Latency measured in cycles is extended by the number of enable-low cycles.

Flags:
- cout = carry out of the final stage.
- ovf = carry into the MSB XOR carry out of the MSB. Equivalently, operand sign bits (after B inversion) agree and the result sign differs.

Boundary cases:
- STAGES=1: the block is a single-cycle registered adder with latency 1.
- WIDTH%STAGES != 0 is an elaboration error.
- Simultaneous rst and enable: reset wins.
- Full carry ripple across all stages, e.g. FFFF+1, must produce a correct result with no extra latency.

Test Plan (WIDTH=16, STAGES=4, enable=1 unless stated):
1. Cross-stage carry: a=16'hFFFF, b=16'h0001, cin=0, sub=0, valid_in for 1 cycle -> exactly 4 cycles later valid_out=1 for one cycle, sum=16'h0000, cout=1, ovf=0.
2. Subtract with borrow: a=16'h0005, b=16'h0007, sub=1, cin=1 (ignored) -> sum=16'hFFFE, cout=0, ovf=0. Then a=16'h0007, b=16'h0005 -> sum=16'h0002, cout=1.
3. Signed overflow: a=16'h7FFF, b=16'h0001, sub=0 -> sum=16'h8000, cout=0, ovf=1. Then a=16'h8000, b=16'h0001, sub=1 -> sum=16'h7FFF, cout=1, ovf=1.
4. Streaming: issue back-to-back 0001+0001, 00FF+0001, 0FFF+0001, 1234+4321, followed by a bubble -> valid_out high on 4 consecutive cycles with sums 0002, 0100, 1000, 5555 in order, then valid_out=0, and sum holds 5555.
5. Stall: issue 2 ops, drop enable for 3 cycles at cycle 2 -> valid_out=0 and sum/cout/ovf frozen during the stall. Both results appear correct 3 cycles later than unstalled, with no duplicates.
6. Reset mid-flight: issue 3 ops, assert rst for 1 cycle at cycle 2 -> next cycle sum=0, cout=0, ovf=0, valid_out=0, and none of the 3 results ever appears. An op issued after reset returns correctly with latency 4.
